// File: rtl/pipe_stage_buf.sv
// Skid/elastic buffer between two pipeline stages (e.g. IF -> ID).
// Circular FIFO of DEPTH {pc, inst} entries. A redirect (flush) empties it;
// if the producer stage is stalled when the flush arrives, the flush is held
// in flush_pend and applied on the first cycle the producer is released.
module pipe_stage_buf #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 2,
   parameter int STAGE  = 1
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [5:0]                   stall,
   input  logic                         flush,
   input  logic                         if_valid,
   input  logic [PC_W-1:0]              if_pc,
   input  logic [INST_W-1:0]            if_inst,
   output logic                         if_ready,
   output logic                         id_valid,
   output logic [PC_W-1:0]              id_pc,
   output logic [INST_W-1:0]            id_inst,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   logic [PC_W-1:0]   mem_pc   [DEPTH];
   logic [INST_W-1:0] mem_inst [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              flush_pend;

   logic stall_up;
   logic stall_dn;
   logic push;
   logic pop;
   logic clear;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   // Handshake decode. Only the producer and consumer stall bits matter.
   always_comb begin
      stall_up = stall[STAGE];
      stall_dn = stall[STAGE+1];
      if_ready = (count < DEPTH_C) && !stall_up && !flush && !flush_pend;
      push     = if_valid && if_ready;
      pop      = (count != '0) && !stall_dn && !flush && !flush_pend;
      // A flush (new or pending) takes effect only when the producer moves.
      clear    = !stall_up && (flush || flush_pend);
   end

   // Head presentation; payload is forced to zero whenever nothing is issued.
   always_comb begin
      id_valid = (count != '0) && !flush_pend;
      id_pc    = id_valid ? mem_pc[rd_ptr]   : '0;
      id_inst  = id_valid ? mem_inst[rd_ptr] : '0;
   end

   // Occupancy, pointers and the deferred-flush flag.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         flush_pend <= 1'b0;
      end else if (clear) begin
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         flush_pend <= 1'b0;
      end else begin
         // Reaching here with flush set means the producer is stalled.
         if (flush) flush_pend <= 1'b1;
         if (push)  wr_ptr <= ptr_next(wr_ptr);
         if (pop)   rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are masked by count so they need no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_pc[wr_ptr]   <= if_pc;
         mem_inst[wr_ptr] <= if_inst;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf (DEPTH=2, STAGE=1: stall[1] producer, stall[2] consumer).
module tb_pipe_stage_buf;

   localparam int DEPTH = 2;
   localparam int STAGE = 1;

   logic        CLK;
   logic        RST;
   logic [5:0]  stall;
   logic        flush;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [1:0]  count;

   int checks = 0;
   int errors = 0;

   pipe_stage_buf #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH), .STAGE(STAGE)) dut (
      .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
      .id_inst(id_inst), .count(count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an ordered list of entries plus a pending-flush bit.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t m_q[$];
   bit   m_pend;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_q.delete();
         m_pend = 1'b0;
      end else if (m_pend) begin
         if (!stall[STAGE]) begin
            m_q.delete();
            m_pend = 1'b0;
         end
      end else if (flush) begin
         if (stall[STAGE]) m_pend = 1'b1;
         else              m_q.delete();
      end else begin
         bit do_pop;
         bit do_push;
         ent_t e;
         do_pop  = (m_q.size() > 0) && !stall[STAGE+1];
         do_push = if_valid && (m_q.size() < DEPTH) && !stall[STAGE];
         e.pc    = if_pc;
         e.inst  = if_inst;
         if (do_pop)  void'(m_q.pop_front());
         if (do_push) m_q.push_back(e);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      if (!RST) begin
         bit          e_valid;
         logic [31:0] e_pc;
         logic [31:0] e_inst;
         e_valid = (m_q.size() > 0) && !m_pend;
         e_pc    = e_valid ? m_q[0].pc   : 32'h0;
         e_inst  = e_valid ? m_q[0].inst : 32'h0;
         chk("m_count",    32'(count),    32'(m_q.size()));
         chk("m_id_valid", 32'(id_valid), 32'(e_valid));
         chk("m_id_pc",    id_pc,         e_pc);
         chk("m_id_inst",  id_inst,       e_inst);
         chk("m_if_ready", 32'(if_ready),
             32'((m_q.size() < DEPTH) && !stall[STAGE] && !flush && !m_pend));
      end
   end

   task automatic set(input logic v, input logic [31:0] pc, input logic [5:0] st, input logic fl);
      if_valid = v;
      if_pc    = pc;
      if_inst  = pc ^ 32'hDEAD_0000;
      stall    = st;
      flush    = fl;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1;
      set(1'b0, 32'h0, 6'b0, 1'b0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      chk("rst_id_valid", 32'(id_valid), 32'h0);
      chk("rst_count",    32'(count),    32'h0);
      chk("rst_if_ready", 32'(if_ready), 32'h1);
      chk("rst_id_pc",    id_pc,         32'h0);

      // Streaming at full rate: occupancy stays at one.
      set(1'b1, 32'h0, 6'b0, 1'b0); tick();
      chk("str0_pc", id_pc, 32'h0);  chk("str0_cnt", 32'(count), 32'h1);
      chk("str0_inst", id_inst, 32'hDEAD_0000);
      set(1'b1, 32'h4, 6'b0, 1'b0); tick();
      chk("str1_pc", id_pc, 32'h4);  chk("str1_cnt", 32'(count), 32'h1);
      set(1'b1, 32'h8, 6'b0, 1'b0); tick();
      chk("str2_pc", id_pc, 32'h8);  chk("str2_cnt", 32'(count), 32'h1);
      set(1'b0, 32'h0, 6'b0, 1'b0); tick();
      chk("str_drain", 32'(count), 32'h0);

      // Unrelated stall bits must not disturb streaming.
      for (int i = 0; i < 3; i++) begin
         set(1'b1, 32'h100 + 32'(i * 4), 6'b111001, 1'b0); tick();
         chk("ign_pc", id_pc, 32'h100 + 32'(i * 4));
      end
      set(1'b0, 32'h0, 6'b0, 1'b0); tick();

      // Consumer stalled: buffer fills to DEPTH then refuses.
      set(1'b1, 32'h10, 6'b000100, 1'b0); tick();
      chk("full1_cnt", 32'(count), 32'h1);
      set(1'b1, 32'h14, 6'b000100, 1'b0); tick();
      chk("full2_cnt", 32'(count), 32'h2);
      set(1'b1, 32'h18, 6'b000100, 1'b0); #1;
      chk("full_ready", 32'(if_ready), 32'h0);
      tick();
      chk("full3_cnt", 32'(count), 32'h2);
      chk("full3_pc",  id_pc,      32'h10);
      set(1'b0, 32'h0, 6'b0, 1'b0); tick();
      chk("rel1_pc", id_pc, 32'h14);
      tick();
      chk("rel2_valid", 32'(id_valid), 32'h0);

      // Flush with producer running.
      set(1'b1, 32'h20, 6'b000100, 1'b0); tick();
      set(1'b1, 32'h24, 6'b000100, 1'b0); tick();
      set(1'b1, 32'h28, 6'b000000, 1'b1); tick();
      chk("fl_cnt",   32'(count),    32'h0);
      chk("fl_valid", 32'(id_valid), 32'h0);
      chk("fl_pc",    id_pc,         32'h0);
      set(1'b0, 32'h0, 6'b0, 1'b0); tick();
      chk("fl_drop", 32'(count), 32'h0);

      // Flush while producer stalled: deferred, masked, then applied.
      set(1'b1, 32'h2C, 6'b0, 1'b0); tick();
      set(1'b0, 32'h0, 6'b000010, 1'b1); tick();
      chk("fp_valid0", 32'(id_valid), 32'h0);
      chk("fp_cnt0",   32'(count),    32'h1);
      set(1'b0, 32'h0, 6'b000010, 1'b0); tick();
      chk("fp_valid1", 32'(id_valid), 32'h0);
      set(1'b0, 32'h0, 6'b000010, 1'b1); tick();
      chk("fp_valid2", 32'(id_valid), 32'h0);
      set(1'b1, 32'h30, 6'b0, 1'b0); #1;
      chk("fp_ready", 32'(if_ready), 32'h0);
      tick();
      chk("fp_clr_cnt", 32'(count), 32'h0);
      set(1'b1, 32'h34, 6'b0, 1'b0); tick();
      chk("fp_acc_pc", id_pc, 32'h34);
      set(1'b0, 32'h0, 6'b0, 1'b0); tick();

      // Bubble: producer stalled, consumer drains the single entry.
      set(1'b1, 32'h38, 6'b0, 1'b0); tick();
      set(1'b1, 32'h3C, 6'b000010, 1'b0); tick();
      chk("bub_valid", 32'(id_valid), 32'h0);
      chk("bub_pc",    id_pc,         32'h0);
      tick();
      chk("bub_cnt", 32'(count), 32'h0);
      set(1'b1, 32'h3C, 6'b0, 1'b0); tick();
      chk("bub_res_pc", id_pc, 32'h3C);
      set(1'b0, 32'h0, 6'b0, 1'b0); tick();

      // Asynchronous reset mid-operation with a full buffer and pending flush.
      set(1'b1, 32'h50, 6'b000100, 1'b0); tick();
      set(1'b1, 32'h54, 6'b000100, 1'b0); tick();
      set(1'b0, 32'h0, 6'b000110, 1'b1); tick();
      set(1'b0, 32'h0, 6'b0, 1'b0);
      #1 RST = 1'b1;
      #1;
      chk("ar_cnt",   32'(count),    32'h0);
      chk("ar_valid", 32'(id_valid), 32'h0);
      chk("ar_pc",    id_pc,         32'h0);
      RST = 1'b0;
      set(1'b1, 32'h40, 6'b0, 1'b0); tick();
      chk("ar_push_pc",  id_pc,      32'h40);
      chk("ar_push_cnt", 32'(count), 32'h1);
      set(1'b0, 32'h0, 6'b0, 1'b0); tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
